// File: rtl/ppi_strobed.sv
// rtl/ppi_strobed.sv - multi-port peripheral interface with basic and strobed handshake modes
// Each port is a plain I/O port or a strobed input/output port; tri-states live in the wrapper.
module ppi_strobed #(
  parameter int NPORTS = 3,
  parameter int WIDTH  = 8,
  parameter int AW     = $clog2(2*NPORTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cs,
  input  logic                     rd,
  input  logic                     wr,
  input  logic [AW-1:0]            a,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  input  logic [NPORTS*WIDTH-1:0]  port_in,
  output logic [NPORTS*WIDTH-1:0]  port_out,
  output logic [NPORTS-1:0]        port_oe,
  input  logic [NPORTS-1:0]        stb_n,
  input  logic [NPORTS-1:0]        ack_n,
  output logic [NPORTS-1:0]        ibf,
  output logic [NPORTS-1:0]        obf_n,
  output logic [NPORTS-1:0]        intr,
  output logic                     irq
);

  logic              wr_q, rd_q;
  logic [AW-1:0]     a_lat;
  logic              wr_pulse, rd_fall;

  logic [NPORTS-1:0] stb_s1, stb_s2, stb_s3;
  logic [NPORTS-1:0] ack_s1, ack_s2, ack_s3;
  logic [NPORTS-1:0] stb_fall, ack_fall;

  logic [NPORTS-1:0] dir_r, mode_r, ie_r;
  logic [NPORTS-1:0] ibf_r, obf_r, ovr_r, ackf_r;
  logic [WIDTH-1:0]  in_r    [NPORTS];
  logic [WIDTH-1:0]  latch_r [NPORTS];
  logic [WIDTH-1:0]  out_r   [NPORTS];

  logic [NPORTS-1:0] data_wr_hit, ctrl_wr_hit, data_rd_hit;

  assign wr_pulse = cs && wr && !wr_q;
  assign rd_fall  = rd_q && !(cs && rd);
  assign stb_fall = stb_s3 & ~stb_s2;
  assign ack_fall = ack_s3 & ~ack_s2;

  always_comb begin
    data_wr_hit = '0;
    ctrl_wr_hit = '0;
    data_rd_hit = '0;
    for (int i = 0; i < NPORTS; i++) begin
      data_wr_hit[i] = wr_pulse && (a == AW'(2*i));
      ctrl_wr_hit[i] = wr_pulse && (a == AW'(2*i+1));
      data_rd_hit[i] = rd_fall  && (a_lat == AW'(2*i));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      a_lat   <= '0;
      stb_s1  <= '1;
      stb_s2  <= '1;
      stb_s3  <= '1;
      ack_s1  <= '1;
      ack_s2  <= '1;
      ack_s3  <= '1;
      dir_r   <= '0;
      mode_r  <= '0;
      ie_r    <= '0;
      ibf_r   <= '0;
      obf_r   <= '0;
      ovr_r   <= '0;
      ackf_r  <= '0;
      for (int i = 0; i < NPORTS; i++) begin
        in_r[i]    <= '0;
        latch_r[i] <= '0;
        out_r[i]   <= '0;
      end
    end else begin
      wr_q   <= cs && wr;
      rd_q   <= cs && rd;
      if (cs && rd) a_lat <= a;
      stb_s1 <= stb_n;
      stb_s2 <= stb_s1;
      stb_s3 <= stb_s2;
      ack_s1 <= ack_n;
      ack_s2 <= ack_s1;
      ack_s3 <= ack_s2;

      for (int i = 0; i < NPORTS; i++) begin
        in_r[i] <= port_in[i*WIDTH +: WIDTH];

        if (data_rd_hit[i]) begin
          ibf_r[i] <= 1'b0;
          ovr_r[i] <= 1'b0;
        end
        // A read clearing the buffer in the same clk lets the strobe latch cleanly.
        if (stb_fall[i] && mode_r[i] && !dir_r[i]) begin
          if (!ibf_r[i] || data_rd_hit[i]) begin
            latch_r[i] <= in_r[i];
            ibf_r[i]   <= 1'b1;
            ovr_r[i]   <= 1'b0;
          end else begin
            ovr_r[i]   <= 1'b1;
          end
        end

        if (ack_fall[i] && mode_r[i] && dir_r[i] && obf_r[i]) begin
          obf_r[i]  <= 1'b0;
          ackf_r[i] <= 1'b1;
        end
        // Placed after the ack handling so a coincident bus write wins.
        if (data_wr_hit[i]) begin
          out_r[i] <= din;
          if (mode_r[i] && dir_r[i]) begin
            obf_r[i]  <= 1'b1;
            ackf_r[i] <= 1'b0;
          end
        end

        if (ctrl_wr_hit[i]) begin
          dir_r[i]  <= din[0];
          mode_r[i] <= din[1];
          ie_r[i]   <= din[2];
          ibf_r[i]  <= 1'b0;
          obf_r[i]  <= 1'b0;
          ovr_r[i]  <= 1'b0;
          ackf_r[i] <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    port_out = '0;
    for (int i = 0; i < NPORTS; i++) begin
      port_out[i*WIDTH +: WIDTH] = out_r[i];
      ibf[i]   = ibf_r[i] && mode_r[i] && !dir_r[i];
      obf_n[i] = !(obf_r[i] && mode_r[i] && dir_r[i]);
      intr[i]  = ie_r[i] && mode_r[i] && (dir_r[i] ? ackf_r[i] : ibf_r[i]);
    end
  end

  assign port_oe = dir_r;
  assign irq     = |intr;

  always_comb begin
    dout = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (a == AW'(2*i)) begin
        if (dir_r[i])       dout = out_r[i];
        else if (mode_r[i]) dout = latch_r[i];
        else                dout = in_r[i];
      end else if (a == AW'(2*i+1)) begin
        dout[6:0] = {ovr_r[i], intr[i], obf_r[i], ibf_r[i], ie_r[i], mode_r[i], dir_r[i]};
      end
    end
  end

endmodule
